dmem_bridge: RTL and testbench

- Data-memory access stage downstream of the core's MEM stage.
- Converts the core's M-stage load/store request (address, write data, size/sign controls) into an SRAM-like bus transaction with req/addr_ok/data_ok handshake.
- Generates byte strobes, extracts and sign/zero-extends load data, detects misaligned accesses, and stalls the pipeline until the transaction completes.

---
 rtl/dmem_bridge.sv | 232 +++++++++++++++++++++++
 tb/tb_dmem_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: converts the M-stage load/store request into an SRAM-like
// req/addr_ok/data_ok bus transaction. It generates byte strobes, extends
// load data, flags misaligned accesses and stalls the pipeline until the
// transaction completes.
// Optional feature: define DMEM_BUS_TIMEOUT_EN to abort transactions that
// spend TIMEOUT_CYC cycles in REQ+WAIT (pulses bus_errM).
module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic [1:0]  DMwrite_ctrl,
  input  logic [2:0]  DMread_ctrl,
  input  logic        flushM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        adelM,
  output logic        adesM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        bus_errM
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        is_store;
  logic        is_load;
  logic        access;
  logic        misaligned;
  logic        req_ok;
  logic        start;
  logic [1:0]  size;
  logic        cancel_q;
  logic        capture;
  logic        abort;
  logic        orphan;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // A simultaneous read+write request is treated as a write
  assign is_store = memwriteM;
  assign is_load  = memreadM & ~memwriteM;
  assign access   = (memreadM | memwriteM) & ~flushM;

  // Access size encoding: 0 byte, 1 half, 2 word (reserved codes -> word)
  always_comb begin
    size = 2'd2;
    if (is_store) begin
      case (DMwrite_ctrl)
        2'b01:   size = 2'd1;
        2'b10:   size = 2'd0;
        default: size = 2'd2;
      endcase
    end else begin
      case (DMread_ctrl)
        3'b001, 3'b010: size = 2'd1;
        3'b011, 3'b100: size = 2'd0;
        default:        size = 2'd2;
      endcase
    end
  end

  assign misaligned = ((size == 2'd1) && aluoutM[0]) ||
                      ((size == 2'd2) && (aluoutM[1:0] != 2'b00));
  assign adelM      = is_load & misaligned;
  assign adesM      = is_store & misaligned;
  assign req_ok     = access & ~misaligned;
  // No new request in the abort-report cycle or while an aborted reply is owed
  assign start      = req_ok & ~bus_errM & ~orphan;

  assign data_addr  = aluoutM;
  assign data_size  = size;
  assign data_wr    = is_store;

  // Byte-lane strobes and lane-replicated write data
  always_comb begin
    data_wstrb = 4'b0000;
    data_wdata = writedataM;
    if (is_store) begin
      case (size)
        2'd0: begin
          data_wstrb = 4'b0001 << aluoutM[1:0];
          data_wdata = {4{writedataM[7:0]}};
        end
        2'd1: begin
          data_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
          data_wdata = {2{writedataM[15:0]}};
        end
        default: data_wstrb = 4'b1111;
      endcase
    end
  end

  // Lane selection and sign/zero extension of the returned word
  always_comb begin
    case (aluoutM[1:0])
      2'd0:    byte_sel = data_rdata[7:0];
      2'd1:    byte_sel = data_rdata[15:8];
      2'd2:    byte_sel = data_rdata[23:16];
      default: byte_sel = data_rdata[31:24];
    endcase
    half_sel = aluoutM[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (DMread_ctrl)
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_ext = {16'h0000, half_sel};
      3'b011:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      default: load_ext = data_rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start) state_next = S_REQ;
      S_REQ: begin
        if (flushM)                            state_next = S_IDLE;
        else if (data_addr_ok && data_data_ok) state_next = S_DONE;
        else if (data_addr_ok)                 state_next = S_WAIT;
        else if (abort)                        state_next = S_IDLE;
      end
      S_WAIT: begin
        if (data_data_ok)  state_next = (cancel_q || flushM) ? S_IDLE : S_DONE;
        else if (abort)    state_next = S_IDLE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: bus request and pipeline stall
  always_comb begin
    data_req = 1'b0;
    stallM   = 1'b0;
    unique case (state)
      S_IDLE: stallM = req_ok & ~bus_errM & rst;
      S_REQ: begin
        data_req = ~flushM;
        stallM   = 1'b1;
      end
      S_WAIT: stallM = 1'b1;
      default: ;
    endcase
  end

  // A flush during WAIT discards the reply that is still in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       cancel_q <= 1'b0;
    else if (state == S_WAIT && state_next == S_WAIT) cancel_q <= cancel_q | flushM;
    else                                            cancel_q <= 1'b0;
  end

  // Load result is registered on the cycle the reply arrives, visible in DONE
  assign capture = (state_next == S_DONE) && is_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         readdataM <= 32'h0000_0000;
    else if (capture) readdataM <= load_ext;
  end

`ifdef DMEM_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             in_bus;
  logic             timeout_hit;
  logic             orphan_q;

  assign in_bus      = (state == S_REQ) || (state == S_WAIT);
  assign timeout_hit = in_bus && (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));
  assign abort       = timeout_hit &&
                       (((state == S_REQ) && !flushM && !data_addr_ok) ||
                        ((state == S_WAIT) && !data_data_ok));
  assign orphan      = orphan_q;

  // Cycles spent in REQ+WAIT for the current transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else if (in_bus && (state_next == S_REQ || state_next == S_WAIT))
      cnt_q <= cnt_q + CNT_W'(1);
    else
      cnt_q <= '0;
  end

  // Error pulse, and swallow the late reply of a transaction aborted in WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_errM <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      bus_errM <= abort;
      if (abort && state == S_WAIT) orphan_q <= 1'b1;
      else if (data_data_ok)        orphan_q <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT_CYC == 32'd0);
  assign abort      = 1'b0;
  assign orphan     = 1'b0;
  assign bus_errM   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: table of load/store vectors with a
// latency-programmable bus responder, plus flush, reset and timeout sequences.
module tb_dmem_bridge;

  logic        clk;
  logic        rst;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [1:0]  DMwrite_ctrl;
  logic [2:0]  DMread_ctrl;
  logic        flushM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        adelM;
  logic        adesM;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_errM;

  dmem_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM), .aluoutM(aluoutM),
    .writedataM(writedataM), .DMwrite_ctrl(DMwrite_ctrl), .DMread_ctrl(DMread_ctrl),
    .flushM(flushM), .readdataM(readdataM), .stallM(stallM),
    .adelM(adelM), .adesM(adesM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .bus_errM(bus_errM)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wctrl;
    logic [2:0]  rctrl;
    logic [31:0] rdata;
    int          alat;
    int          dlat;
    logic        misal;
    logic [3:0]  strb;
    logic [31:0] xwd;
    logic [1:0]  size;
    logic [31:0] xrd;
  } vec_t;

  localparam int NVEC = 18;

  vec_t        vecs [NVEC];
  logic [31:0] sb_q [$];
  logic [31:0] last_rd;
  int          checks;
  int          errors;
  int          addr_lat;
  int          data_lat;
  int          req_wait;
  int          wait_cnt;
  bit          in_data;
  int          hs_stalls;
  bit          hs_seen;
  bit          hs_done;
  bit          hs_flushed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus responder: addr_ok after addr_lat idle REQ cycles, data_ok data_lat cycles later
  initial begin
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    req_wait = 0;
    wait_cnt = 0;
    in_data  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (!rst) begin
        in_data  = 1'b0;
        req_wait = 0;
      end else if (in_data) begin
        wait_cnt++;
        if (wait_cnt >= data_lat) begin
          data_data_ok = 1'b1;
          in_data = 1'b0;
        end
      end else if (data_req) begin
        if (req_wait >= addr_lat) begin
          data_addr_ok = 1'b1;
          req_wait = 0;
          if (data_lat == 0) data_data_ok = 1'b1;
          else begin
            in_data  = 1'b1;
            wait_cnt = 0;
          end
        end else begin
          req_wait++;
        end
      end else begin
        req_wait = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] wctrl,
                              input logic [2:0] rctrl, input logic [31:0] rdata,
                              input int alat, input int dlat, input logic misal,
                              input logic [3:0] strb, input logic [31:0] xwd,
                              input logic [1:0] size, input logic [31:0] xrd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.wctrl = wctrl;
    v.rctrl = rctrl; v.rdata = rdata; v.alat = alat; v.dlat = dlat; v.misal = misal;
    v.strb = strb; v.xwd = xwd; v.size = size; v.xrd = xrd;
    return v;
  endfunction

  // Drive one access, check bus-side fields and stall length, score the result
  task automatic run_txn(input vec_t v, input string tag);
    int          stalls;
    bit          seen_req;
    bit          done;
    logic [31:0] exp;
    addr_lat = v.alat;
    data_lat = v.dlat;
    @(negedge clk);
    memreadM = v.rd; memwriteM = v.wr; aluoutM = v.addr; writedataM = v.wdata;
    DMwrite_ctrl = v.wctrl; DMread_ctrl = v.rctrl; data_rdata = v.rdata;
    #1;
    chk({tag, "_adel"}, 32'(adelM), 32'(v.misal & v.rd & ~v.wr));
    chk({tag, "_ades"}, 32'(adesM), 32'(v.misal & v.wr));
    if (v.misal) begin
      repeat (3) begin
        chk({tag, "_misal_stall"}, 32'(stallM), 32'd0);
        chk({tag, "_misal_req"}, 32'(data_req), 32'd0);
        @(negedge clk);
        #1;
      end
    end else begin
      sb_q.push_back((v.rd && !v.wr) ? v.xrd : last_rd);
      stalls = 0;
      seen_req = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 64; c++) begin
        if (!stallM) begin
          done = 1'b1;
          break;
        end
        stalls++;
        if (data_req && !seen_req) begin
          seen_req = 1'b1;
          chk({tag, "_addr"}, data_addr, v.addr);
          chk({tag, "_wr"}, 32'(data_wr), 32'(v.wr));
          chk({tag, "_size"}, 32'(data_size), 32'(v.size));
          chk({tag, "_wstrb"}, 32'(data_wstrb), 32'(v.strb));
          if (v.wr) chk({tag, "_wdata"}, data_wdata, v.xwd);
        end
        @(negedge clk);
        #1;
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_req_seen"}, 32'(seen_req), 32'd1);
      chk({tag, "_stall_cycles"}, 32'(stalls), 32'(v.alat + v.dlat + 2));
      exp = sb_q.pop_front();
      chk({tag, "_readdata"}, readdataM, exp);
      if (v.rd && !v.wr) last_rd = v.xrd;
    end
    memreadM = 1'b0;
    memwriteM = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; last_rd = 32'h0;
    addr_lat = 0; data_lat = 0;
    rst = 1'b0; memreadM = 1'b0; memwriteM = 1'b0; aluoutM = 32'h0; writedataM = 32'h0;
    DMwrite_ctrl = 2'b00; DMread_ctrl = 3'b000; flushM = 1'b0; data_rdata = 32'h0;

    //            rd    wr    addr          wdata         wc     rc      rdata         al dl mis   strb     xwd           sz     xrd
    vecs[0]  = mk(1'b1, 1'b0, 32'h0000_0100, 32'h0,        2'b00, 3'b000, 32'hDEADBEEF, 0, 0, 1'b0, 4'b0000, 32'h0,        2'd2, 32'hDEADBEEF);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0000_0103, 32'h0,        2'b00, 3'b011, 32'h80112233, 0, 0, 1'b0, 4'b0000, 32'h0,        2'd0, 32'hFFFFFF80);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0000_0103, 32'h0,        2'b00, 3'b100, 32'h80112233, 0, 0, 1'b0, 4'b0000, 32'h0,        2'd0, 32'h00000080);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0000_0102, 32'h0,        2'b00, 3'b001, 32'h80112233, 0, 0, 1'b0, 4'b0000, 32'h0,        2'd1, 32'hFFFF8011);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0000_0100, 32'h0,        2'b00, 3'b010, 32'h80112233, 2, 1, 1'b0, 4'b0000, 32'h0,        2'd1, 32'h00002233);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0000_0101, 32'h0,        2'b00, 3'b011, 32'h80112233, 0, 2, 1'b0, 4'b0000, 32'h0,        2'd0, 32'h00000022);
    vecs[6]  = mk(1'b0, 1'b1, 32'h0000_0201, 32'h000000AB, 2'b10, 3'b000, 32'h0,        0, 0, 1'b0, 4'b0010, 32'hABABABAB, 2'd0, 32'h0);
    vecs[7]  = mk(1'b0, 1'b1, 32'h0000_0202, 32'h00001234, 2'b01, 3'b000, 32'h0,        1, 0, 1'b0, 4'b1100, 32'h12341234, 2'd1, 32'h0);
    vecs[8]  = mk(1'b0, 1'b1, 32'h0000_0200, 32'hBEEF55AA, 2'b01, 3'b000, 32'h0,        0, 0, 1'b0, 4'b0011, 32'h55AA55AA, 2'd1, 32'h0);
    vecs[9]  = mk(1'b0, 1'b1, 32'h0000_0204, 32'hCAFEF00D, 2'b00, 3'b000, 32'h0,        1, 1, 1'b0, 4'b1111, 32'hCAFEF00D, 2'd2, 32'h0);
    vecs[10] = mk(1'b0, 1'b1, 32'h0000_0208, 32'h01020304, 2'b11, 3'b000, 32'h0,        0, 0, 1'b0, 4'b1111, 32'h01020304, 2'd2, 32'h0);
    vecs[11] = mk(1'b1, 1'b1, 32'h0000_020F, 32'h0A0B0C0D, 2'b10, 3'b000, 32'h0,        0, 0, 1'b0, 4'b1000, 32'h0D0D0D0D, 2'd0, 32'h0);
    vecs[12] = mk(1'b1, 1'b0, 32'h0000_0102, 32'h0,        2'b00, 3'b000, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        2'd2, 32'h0);
    vecs[13] = mk(1'b0, 1'b1, 32'h0000_0301, 32'h00001234, 2'b01, 3'b000, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        2'd1, 32'h0);
    vecs[14] = mk(1'b1, 1'b0, 32'h0000_0101, 32'h0,        2'b00, 3'b001, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        2'd1, 32'h0);
    vecs[15] = mk(1'b1, 1'b0, 32'h0000_010C, 32'h0,        2'b00, 3'b000, 32'h12345678, 3, 2, 1'b0, 4'b0000, 32'h0,        2'd2, 32'h12345678);
    vecs[16] = mk(1'b1, 1'b0, 32'h0000_0108, 32'h0,        2'b00, 3'b111, 32'hA5A5A5A5, 0, 0, 1'b0, 4'b0000, 32'h0,        2'd2, 32'hA5A5A5A5);
    vecs[17] = mk(1'b0, 1'b1, 32'h0000_0303, 32'h000000FF, 2'b10, 3'b000, 32'h0,        0, 0, 1'b0, 4'b1000, 32'hFFFFFFFF, 2'd0, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_readdata", readdataM, 32'h0);
    chk("reset_stall", 32'(stallM), 32'd0);
    chk("reset_req", 32'(data_req), 32'd0);
    chk("reset_buserr", 32'(bus_errM), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Flush during WAIT: reply is consumed, no DONE capture, back to IDLE
    addr_lat = 1; data_lat = 3;
    @(negedge clk);
    memreadM = 1'b1; aluoutM = 32'h0000_0110; DMread_ctrl = 3'b000; data_rdata = 32'h55555555;
    #1;
    hs_stalls = 0; hs_seen = 1'b0; hs_done = 1'b0; hs_flushed = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (!stallM) begin
        hs_done = 1'b1;
        break;
      end
      hs_stalls++;
      if (data_req) hs_seen = 1'b1;
      else if (hs_seen && !hs_flushed) begin
        flushM = 1'b1;
        hs_flushed = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    chk("flush_done", 32'(hs_done), 32'd1);
    chk("flush_stall_cycles", 32'(hs_stalls), 32'd6);
    chk("flush_readdata", readdataM, last_rd);
    @(negedge clk);
    #1;
    chk("flush_idle_req", 32'(data_req), 32'd0);
    memreadM = 1'b0; flushM = 1'b0;
    run_txn(vecs[0], "post_flush");

    // Asynchronous reset while waiting for data
    addr_lat = 0; data_lat = 5;
    @(negedge clk);
    memreadM = 1'b1; aluoutM = 32'h0000_0104; DMread_ctrl = 3'b000; data_rdata = 32'h0BADF00D;
    #1;
    hs_seen = 1'b0; hs_done = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (data_req) hs_seen = 1'b1;
      else if (hs_seen && stallM) begin
        hs_done = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("rst_wait_reached", 32'(hs_done), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stallM), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_readdata", readdataM, 32'h0);
    chk("rst_buserr", 32'(bus_errM), 32'd0);
    last_rd = 32'h0;
    @(negedge clk);
    memreadM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_txn(vecs[3], "post_rst");

`ifdef DMEM_BUS_TIMEOUT_EN
    // Bus never answers: abort after TIMEOUT_CYC cycles in REQ
    addr_lat = 1000; data_lat = 0;
    @(negedge clk);
    memreadM = 1'b1; aluoutM = 32'h0000_0120; DMread_ctrl = 3'b000;
    #1;
    hs_stalls = 0; hs_done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (!stallM) begin
        hs_done = 1'b1;
        break;
      end
      hs_stalls++;
      @(negedge clk);
      #1;
    end
    chk("timeout_done", 32'(hs_done), 32'd1);
    chk("timeout_stall_cycles", 32'(hs_stalls), 32'd9);
    chk("timeout_buserr", 32'(bus_errM), 32'd1);
    chk("timeout_readdata", readdataM, last_rd);
    chk("timeout_req", 32'(data_req), 32'd0);
    memreadM = 1'b0;
    @(negedge clk);
    #1;
    chk("timeout_pulse_end", 32'(bus_errM), 32'd0);
    addr_lat = 0;
    run_txn(vecs[0], "post_timeout");
`else
    chk("buserr_tied_low", 32'(bus_errM), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound on simulation time
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
